alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_valid  input  1  operation request, qualified by o_ready.
REQ-005 o_ready  output  1  block can accept a request this cycle.
REQ-006 i_aluControl  input  4  operation code from the ALU control decoder.
REQ-007 i_srcA  input  WIDTH  operand A.
REQ-008 i_srcB  input  WIDTH  operand B.
REQ-009 o_valid  output  1  result valid; one-cycle pulse per accepted request.
REQ-010 o_result  output  WIDTH  operation result.
REQ-011 o_zero  output  1  high when o_result equals 0.
REQ-012 o_overflow  output  1  signed overflow flag for ADD/SUB.

Function
REQ-013 Codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MUL 1000 (MUL only per REQ-029).
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; IDLE is the reset state.
REQ-015 Acceptance SHALL occur on any edge where i_valid and o_ready are both high; opcode and operands are captured then, and later input changes are ignored.
REQ-016 o_ready SHALL be high in IDLE and DONE and low in EXEC.
REQ-017 A single-cycle op accepted at edge N SHALL produce registered o_result/o_zero/o_overflow with o_valid high in the cycle after edge N (state DONE).
REQ-018 Acceptance in DONE SHALL start the next op directly, allowing one result per cycle for back-to-back single-cycle ops.
REQ-019 DONE without acceptance SHALL return to IDLE; o_valid SHALL be high only in DONE.
REQ-020 o_result, o_zero, o_overflow SHALL hold their last values while o_valid is low.
REQ-021 ADD/SUB SHALL wrap modulo 2^WIDTH; o_overflow SHALL be set on signed overflow (ADD: like-signed operands, result sign differs; SUB: unlike-signed operands, result sign differs from A).
REQ-022 SLT SHALL compare signed and return 1 if A<B else 0, zero-extended.
REQ-023 AND, OR, NOR SHALL be bitwise; o_overflow SHALL be 0 for all ops except ADD/SUB.
REQ-024 Undefined codes SHALL complete as single-cycle ops with o_result=0, o_zero=1, o_overflow=0.
REQ-025 MUL SHALL enter EXEC, run WIDTH shift-add iterations (one per cycle) of an unsigned multiply, and enter DONE; o_valid SHALL be high exactly WIDTH+1 cycles after the accepting edge.
REQ-026 MUL o_result SHALL be the low WIDTH bits of the unsigned product; o_overflow=0.
REQ-027 i_valid during EXEC SHALL be ignored, with no request queued.

Reset
REQ-028 With i_rst high at an edge, the FSM SHALL enter IDLE with o_valid=0, o_ready=1 after the edge, o_result=0, o_zero=1, o_overflow=0, and the iteration counter cleared, aborting any in-flight op (including EXEC) without producing a result.

Configuration
REQ-029 Macro ALU_EXEC_MUL_EN: when defined, MUL (1000) SHALL be implemented per REQ-025/026; when undefined, EXEC state logic and the multiplier SHALL be omitted, and 1000 SHALL be treated as undefined per REQ-024.

Verification
REQ-030 ADD 0x7FFFFFFF+0x00000001 -> next cycle o_valid=1, o_result=0x80000000, o_overflow=1, o_zero=0.
REQ-031 SUB 5-5 then SLT 0xFFFFFFFF vs 1, back-to-back -> consecutive o_valid pulses: (0, o_zero=1), then (1, o_zero=0).
REQ-032 AND/OR/NOR on 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0, 0xFFF0FFF0, 0x000F000F.
REQ-033 With ALU_EXEC_MUL_EN, MUL 12x13 -> o_ready low for 32 cycles, o_valid at cycle 33, o_result=156; without the macro -> o_result=0 next cycle.
REQ-034 i_rst asserted mid-MUL -> no o_valid pulse, o_ready=1 on the next cycle, then ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- handshake-driven ALU execution unit
//
// Purpose:
//   Accepts one ALU operation per request on a valid/ready handshake.
//   Single-cycle operations produce a registered result in the following cycle.
//   The optional unsigned multiply runs one shift-add iteration per cycle.
//   Opcode and operands are sampled only on the accepting edge.
//
// Configuration macro:
//   ALU_EXEC_MUL_EN : when defined, opcode 4'b1000 (MUL) is implemented as a
//                     WIDTH-iteration shift-add multiply through the EXEC
//                     state. When undefined, the multiplier and EXEC logic
//                     are omitted, and 4'b1000 behaves as an undefined code.
//
// Ports:
//   i_clk        in   1      clock, rising edge
//   i_rst        in   1      synchronous active-high reset
//   i_valid      in   1      request, accepted when o_ready is high
//   o_ready      out  1      can accept a request this cycle (low in EXEC)
//   i_aluControl in   4      operation code
//   i_srcA       in   WIDTH  operand A
//   i_srcB       in   WIDTH  operand B
//   o_valid      out  1      result valid (high only in DONE)
//   o_result     out  WIDTH  result, held while o_valid is low
//   o_zero       out  1      o_result == 0
//   o_overflow   out  1      signed overflow for ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_aluControl,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_accept;
  logic             w_alu_load;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_lt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;

  assign o_ready    = (r_state != EXEC);
  assign o_valid    = (r_state == DONE);
  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_overflow = r_ovf;

  assign w_accept = i_valid && o_ready;

  // Single-cycle datapath, evaluated on the live inputs. The result is only
  // consumed on the accepting edge, so later input changes have no effect.
  assign w_sum  = i_srcA + i_srcB;
  assign w_diff = i_srcA - i_srcB;
  assign w_lt   = ($signed(i_srcA) < $signed(i_srcB));

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (i_aluControl)
      OP_AND: w_res = i_srcA & i_srcB;
      OP_OR:  w_res = i_srcA | i_srcB;
      OP_NOR: w_res = ~(i_srcA | i_srcB);
      OP_ADD: begin
        w_res = w_sum;
        // Like-signed operands whose sum flips sign.
        w_ovf = (i_srcA[WIDTH-1] == i_srcB[WIDTH-1]) &&
                (w_sum[WIDTH-1] != i_srcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        // Unlike-signed operands whose difference differs in sign from A.
        w_ovf = (i_srcA[WIDTH-1] != i_srcB[WIDTH-1]) &&
                (w_diff[WIDTH-1] != i_srcA[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  assign w_is_mul   = (i_aluControl == OP_MUL);
  assign w_alu_load = w_accept && !w_is_mul;
  // Only the low WIDTH product bits are kept, so the accumulator and the
  // left-shifting multiplicand never need more than WIDTH bits.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
`else
  assign w_alu_load = w_accept;
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
`ifdef ALU_EXEC_MUL_EN
          w_state_next = w_is_mul ? EXEC : DONE;
`else
          w_state_next = DONE;
`endif
        end else begin
          w_state_next = IDLE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      EXEC: begin
        // i_valid is ignored here: o_ready is low, so w_accept cannot fire.
        if (w_mul_last) begin
          w_state_next = DONE;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result registers and multiplier datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
`endif
    end else begin
      if (w_alu_load) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
      end
`ifdef ALU_EXEC_MUL_EN
      if (w_accept && w_is_mul) begin
        r_mcand  <= i_srcB;
        r_mplier <= i_srcA;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == EXEC) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        // The visible result only changes when the product is complete.
        if (w_mul_last) begin
          r_result <= w_acc_next;
          r_zero   <= (w_acc_next == '0);
          r_ovf    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec (WIDTH = 32)
//
// Expected results are pushed to a scoreboard queue when a request is driven.
// A monitor pops and compares them whenever o_valid is seen high. Cycle-level
// handshake and reset behaviour is checked inline in the stimulus sequence.
// Honours ALU_EXEC_MUL_EN for the MUL expectations.
// -----------------------------------------------------------------------------
module tb_alu_exec;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic         o_zero;
  logic         o_overflow;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_txn = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_aluControl (op),
    .i_srcA       (a),
    .i_srcB       (b),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_zero       (o_zero),
    .o_overflow   (o_overflow)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current (negedge) time and record its result.
  task automatic send(input logic [3:0] o, input logic [W-1:0] sa,
                      input logic [W-1:0] sb_v, input logic [W-1:0] er,
                      input logic ez, input logic eov);
    exp_t e;
    i_valid = 1'b1;
    op      = o;
    a       = sa;
    b       = sb_v;
    e.r  = er;
    e.z  = ez;
    e.ov = eov;
    sb.push_back(e);
  endtask

  // Drop the request and scramble operands to show they are not re-sampled.
  task automatic idle_inputs();
    i_valid = 1'b0;
    op      = 4'($urandom_range(0, 15));
    a       = $urandom;
    b       = $urandom;
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      chk("sb_nonempty", W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        n_txn++;
        chk("result", o_result, e.r);
        chk("zero", W'(o_zero), W'(e.z));
        chk("overflow", W'(o_overflow), W'(e.ov));
        $display("txn %0d: result=%h zero=%b ovf=%b (exp %h %b %b)",
                 n_txn, o_result, o_zero, o_overflow, e.r, e.z, e.ov);
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_result", o_result, '0);
    chk("rst_zero", W'(o_zero), W'(1));
    chk("rst_ovf", W'(o_overflow), W'(0));

    // ADD overflow; then hold check with scrambled inputs
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_valid_next", W'(o_valid), W'(1));
    idle_inputs();
    @(negedge clk);
    chk("hold_valid_low", W'(o_valid), W'(0));
    chk("hold_result", o_result, 32'h8000_0000);
    chk("hold_ovf", W'(o_overflow), W'(1));
    chk("idle_ready", W'(o_ready), W'(1));

    // SUB 5-5 then SLT -1 < 1 back-to-back
    send(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_ready", W'(o_ready), W'(1));
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_second_valid", W'(o_valid), W'(1));
    idle_inputs();
    @(negedge clk);

    // Logic ops back-to-back
    send(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    @(negedge clk);
    send(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    @(negedge clk);
    send(4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0, 1'b0);
    @(negedge clk);

    // Overflow boundaries, SLT false, undefined code
    send(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    send(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    send(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    send(4'b1111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

`ifdef ALU_EXEC_MUL_EN
    // MUL 12x13: busy for 32 cycles, result in cycle 33; requests ignored while busy
    send(4'b1000, 32'd12, 32'd13, 32'd156, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      if (k == 3) begin
        i_valid = 1'b1;
        op      = 4'b0010;
      end
      if (k == 6) i_valid = 1'b0;
      chk("mul_busy", W'(o_ready), W'(0));
    end
    @(negedge clk);
    chk("mul_valid_c33", W'(o_valid), W'(1));
    @(negedge clk);
`else
    // Without the multiplier, MUL is an undefined code
    send(4'b1000, 32'd12, 32'd13, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mul_undef_valid", W'(o_valid), W'(1));
    idle_inputs();
    @(negedge clk);
`endif

    // Reset coinciding with a request aborts it and clears the result
    send(4'b0010, 32'd9, 32'd1, 32'd10, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("pre_rst_result", o_result, 32'd10);
    i_valid = 1'b1;
    op      = 4'b0010;
    a       = 32'd4;
    b       = 32'd4;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    chk("rst_abort_valid", W'(o_valid), W'(0));
    chk("rst_abort_result", o_result, '0);
    chk("rst_abort_zero", W'(o_zero), W'(1));

`ifdef ALU_EXEC_MUL_EN
    // Reset in the middle of a MUL: no result pulse, ready next cycle
    i_valid = 1'b1;
    op      = 4'b1000;
    a       = 32'd7;
    b       = 32'd9;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    chk("midmul_busy", W'(o_ready), W'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midmul_rst_ready", W'(o_ready), W'(1));
    chk("midmul_rst_valid", W'(o_valid), W'(0));
    repeat (40) @(negedge clk);
`endif

    // ADD 2+3 after reset
    send(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_after_rst_valid", W'(o_valid), W'(1));
    idle_inputs();
    repeat (3) @(negedge clk);

    chk("sb_drained", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
